// File: rtl/fifo_scoreboard_checker_if.sv
// ---------------------------------------------------------------------------
// fifo_scoreboard_checker_if
//
// Purpose: groups every signal of a synchronous FIFO that the in-line
// scoreboard checker needs to observe: the write/read requests, the write
// data, and the eight FIFO outputs being checked.
//
// Signals:
//   wr_en, rd_en   FIFO write / read requests
//   data_in        FIFO write data
//   data_out       FIFO read data (registered inside the FIFO)
//   wr_ack         FIFO write acknowledge (registered)
//   overflow       FIFO overflow (registered)
//   underflow      FIFO underflow (registered)
//   full, empty    FIFO occupancy flags
//   almostfull     FIFO almost-full flag
//   almostempty    FIFO almost-empty flag
//
// Modports:
//   master  the side that produces these signals (FIFO plus its stimulus)
//   slave   the observing checker; every signal is an input
// ---------------------------------------------------------------------------
interface fifo_scoreboard_checker_if #(
    parameter int DATA_W = 16
);
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              wr_ack;
    logic              overflow;
    logic              underflow;
    logic              full;
    logic              empty;
    logic              almostfull;
    logic              almostempty;

    modport master (
        output wr_en, rd_en, data_in, data_out, wr_ack, overflow,
               underflow, full, empty, almostfull, almostempty
    );

    modport slave (
        input  wr_en, rd_en, data_in, data_out, wr_ack, overflow,
               underflow, full, empty, almostfull, almostempty
    );
endinterface

// File: rtl/fifo_scoreboard_checker.sv
// ---------------------------------------------------------------------------
// fifo_scoreboard_checker
//
// Purpose: in-line checker that shadows a synchronous FIFO. It keeps its own
// reference model of the FIFO contents and occupancy, compares all eight FIFO
// outputs against the model every enabled cycle, and keeps per-signal
// saturating error/correct counters plus a capture of the first mismatch.
//
// Ports:
//   clk              clock, all logic on the rising edge
//   rst_n            synchronous active-low reset
//   mon              observed FIFO signals (slave modport, all inputs)
//   check_en_i       1 = compare and count this cycle
//   cnt_sel_i        counter select (0 data_out, 1 wr_ack, 2 overflow,
//                    3 underflow, 4 full, 5 empty, 6 almostfull,
//                    7 almostempty)
//   err_cnt_o        error count of the selected signal (combinational read)
//   ok_cnt_o         correct count of the selected signal (combinational read)
//   err_vec_o        per-signal mismatch of the previous cycle
//   err_sticky_o     set on the first mismatch, held until reset
//   first_err_sel_o  lowest mismatching signal index of the first error
//   first_err_cyc_o  cycle counter value of the cycle that first mismatched
// ---------------------------------------------------------------------------
module fifo_scoreboard_checker #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int AF_TH  = DEPTH - 1,
    parameter int AE_TH  = 1,
    parameter int CNT_W  = 16,
    parameter int CYC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    fifo_scoreboard_checker_if.slave mon,
    input  logic                     check_en_i,
    input  logic [2:0]               cnt_sel_i,
    output logic [CNT_W-1:0]         err_cnt_o,
    output logic [CNT_W-1:0]         ok_cnt_o,
    output logic [7:0]               err_vec_o,
    output logic                     err_sticky_o,
    output logic [2:0]               first_err_sel_o,
    output logic [CYC_W-1:0]         first_err_cyc_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] AF_C    = OCC_W'(AF_TH);
    localparam logic [OCC_W-1:0] AE_C    = OCC_W'(AE_TH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Reference model state
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, wptr_d;
    logic [PTR_W-1:0]  rptr_q, rptr_d;
    logic [OCC_W-1:0]  count_q, count_d;
    logic              exp_wr_ack_q, exp_wr_ack_d;
    logic              exp_overflow_q, exp_overflow_d;
    logic              exp_underflow_q, exp_underflow_d;
    logic [DATA_W-1:0] exp_data_out_q, exp_data_out_d;
    logic              data_valid_q, data_valid_d;
    logic              wr_ok, rd_ok;

    logic exp_full, exp_empty, exp_almostfull, exp_almostempty;

    // Statistics state
    logic [CNT_W-1:0] err_cnt_q [8];
    logic [CNT_W-1:0] err_cnt_d [8];
    logic [CNT_W-1:0] ok_cnt_q  [8];
    logic [CNT_W-1:0] ok_cnt_d  [8];
    logic [7:0]       err_vec_q, err_vec_d;
    logic [7:0]       ok_vec;
    logic [7:0]       mismatch;
    logic [7:0]       compared;
    logic             err_sticky_q, err_sticky_d;
    logic [2:0]       first_err_sel_q, first_err_sel_d;
    logic [CYC_W-1:0] first_err_cyc_q, first_err_cyc_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic [2:0]       low_idx;

    // The flag predictions come straight from the model occupancy, the same
    // way a FIFO derives its flags from its own count.
    assign exp_full        = (count_q == DEPTH_C);
    assign exp_empty       = (count_q == '0);
    assign exp_almostfull  = (count_q == AF_C);
    assign exp_almostempty = (count_q == AE_C);

    // Model next state. A write is only accepted when the model is not full
    // and a read only when it is not empty, so a simultaneous write/read on
    // a full FIFO degenerates to a read plus an overflow, and on an empty
    // FIFO to a write plus an underflow. The predicted read data holds its
    // last value when no read is accepted.
    always_comb begin
        wr_ok           = mon.wr_en & ~exp_full;
        rd_ok           = mon.rd_en & ~exp_empty;
        wptr_d          = wptr_q;
        rptr_d          = rptr_q;
        count_d         = count_q;
        exp_wr_ack_d    = wr_ok;
        exp_overflow_d  = mon.wr_en & exp_full;
        exp_underflow_d = mon.rd_en & exp_empty;
        exp_data_out_d  = exp_data_out_q;
        data_valid_d    = data_valid_q;

        if (wr_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rptr_d         = rptr_q + PTR_W'(1);
            exp_data_out_d = mem_q[rptr_q];
            data_valid_d   = 1'b1;
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Model state register. The model keeps running whether or not checking
    // is enabled so that it stays in step with the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q          <= '0;
            rptr_q          <= '0;
            count_q         <= '0;
            exp_wr_ack_q    <= 1'b0;
            exp_overflow_q  <= 1'b0;
            exp_underflow_q <= 1'b0;
            exp_data_out_q  <= '0;
            data_valid_q    <= 1'b0;
        end else begin
            wptr_q          <= wptr_d;
            rptr_q          <= rptr_d;
            count_q         <= count_d;
            exp_wr_ack_q    <= exp_wr_ack_d;
            exp_overflow_q  <= exp_overflow_d;
            exp_underflow_q <= exp_underflow_d;
            exp_data_out_q  <= exp_data_out_d;
            data_valid_q    <= data_valid_d;
        end
    end

    // Model storage. Contents are deliberately not cleared on reset; the
    // occupancy count alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem_q[wptr_q] <= mon.data_in;
        end
    end

    // Per-signal compare. Read data is only meaningful once the model has
    // produced at least one read, so before that it is neither an error nor
    // a correct compare. Bit order matches the counter select encoding.
    always_comb begin
        mismatch[0] = (mon.data_out    != exp_data_out_q);
        mismatch[1] = (mon.wr_ack      != exp_wr_ack_q);
        mismatch[2] = (mon.overflow    != exp_overflow_q);
        mismatch[3] = (mon.underflow   != exp_underflow_q);
        mismatch[4] = (mon.full        != exp_full);
        mismatch[5] = (mon.empty       != exp_empty);
        mismatch[6] = (mon.almostfull  != exp_almostfull);
        mismatch[7] = (mon.almostempty != exp_almostempty);

        compared    = {7'h7F, data_valid_q};
        err_vec_d   = check_en_i ? (mismatch & compared)  : 8'h00;
        ok_vec      = check_en_i ? (~mismatch & compared) : 8'h00;
    end

    // Statistics next state: saturating counters, first-error capture and
    // the free-running cycle counter. The lowest set mismatch bit wins the
    // first-error index, so scan from the top down and let lower bits
    // overwrite.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            err_cnt_d[i] = err_cnt_q[i];
            ok_cnt_d[i]  = ok_cnt_q[i];
            if (err_vec_d[i] && (err_cnt_q[i] != CNT_MAX)) begin
                err_cnt_d[i] = err_cnt_q[i] + CNT_W'(1);
            end
            if (ok_vec[i] && (ok_cnt_q[i] != CNT_MAX)) begin
                ok_cnt_d[i] = ok_cnt_q[i] + CNT_W'(1);
            end
        end

        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (err_vec_d[i]) begin
                low_idx = 3'(i);
            end
        end

        err_sticky_d    = err_sticky_q;
        first_err_sel_d = first_err_sel_q;
        first_err_cyc_d = first_err_cyc_q;
        if ((err_vec_d != 8'h00) && !err_sticky_q) begin
            err_sticky_d    = 1'b1;
            first_err_sel_d = low_idx;
            first_err_cyc_d = cyc_q;
        end

        cyc_d = cyc_q + CYC_W'(1);
    end

    // Statistics register. A reset cycle clears everything and performs no
    // compare of its own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                err_cnt_q[i] <= '0;
                ok_cnt_q[i]  <= '0;
            end
            err_vec_q       <= 8'h00;
            err_sticky_q    <= 1'b0;
            first_err_sel_q <= 3'd0;
            first_err_cyc_q <= '0;
            cyc_q           <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                err_cnt_q[i] <= err_cnt_d[i];
                ok_cnt_q[i]  <= ok_cnt_d[i];
            end
            err_vec_q       <= err_vec_d;
            err_sticky_q    <= err_sticky_d;
            first_err_sel_q <= first_err_sel_d;
            first_err_cyc_q <= first_err_cyc_d;
            cyc_q           <= cyc_d;
        end
    end

    assign err_cnt_o       = err_cnt_q[cnt_sel_i];
    assign ok_cnt_o        = ok_cnt_q[cnt_sel_i];
    assign err_vec_o       = err_vec_q;
    assign err_sticky_o    = err_sticky_q;
    assign first_err_sel_o = first_err_sel_q;
    assign first_err_cyc_o = first_err_cyc_q;

endmodule

// File: tb/tb_fifo_scoreboard_checker.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_fifo_scoreboard_checker
//
// A small behavioural 8-deep FIFO produces the observed signals, with a few
// fault switches that corrupt individual outputs. Two checkers watch the same
// bus: one with 16-bit counters and one with 2-bit counters for saturation.
// Expected checker outputs are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_fifo_scoreboard_checker;

    logic        clk = 1'b0;
    logic        rstN;
    logic        checkEn;
    logic [2:0]  cntSel;
    logic        forceOvfZero;
    logic        forceAfZero;
    logic        flipEmpty;

    logic [15:0] errCnt, okCnt;
    logic [7:0]  errVec;
    logic        errSticky;
    logic [2:0]  firstErrSel;
    logic [31:0] firstErrCyc;

    logic [1:0]  satErrCnt, satOkCnt;
    logic [7:0]  satErrVec;
    logic        satSticky;
    logic [2:0]  satFirstSel;
    logic [31:0] satFirstCyc;

    int checks = 0;
    int errors = 0;

    fifo_scoreboard_checker_if #(.DATA_W(16)) bus ();

    fifo_scoreboard_checker u_dut (
        .clk             (clk),
        .rst_n           (rstN),
        .mon             (bus),
        .check_en_i      (checkEn),
        .cnt_sel_i       (cntSel),
        .err_cnt_o       (errCnt),
        .ok_cnt_o        (okCnt),
        .err_vec_o       (errVec),
        .err_sticky_o    (errSticky),
        .first_err_sel_o (firstErrSel),
        .first_err_cyc_o (firstErrCyc)
    );

    fifo_scoreboard_checker #(.CNT_W(2)) u_sat (
        .clk             (clk),
        .rst_n           (rstN),
        .mon             (bus),
        .check_en_i      (checkEn),
        .cnt_sel_i       (cntSel),
        .err_cnt_o       (satErrCnt),
        .ok_cnt_o        (satOkCnt),
        .err_vec_o       (satErrVec),
        .err_sticky_o    (satSticky),
        .first_err_sel_o (satFirstSel),
        .first_err_cyc_o (satFirstCyc)
    );

    always #50 clk = ~clk;

    // Behavioural FIFO standing in for the device being shadowed
    logic [15:0] fMem [8];
    logic [2:0]  fW, fR;
    logic [3:0]  fCount;
    logic [15:0] fDataOut;
    logic        fWrAck, fOvf, fUdf;
    logic        fWok, fRok;

    assign fWok = bus.wr_en && (fCount != 4'd8);
    assign fRok = bus.rd_en && (fCount != 4'd0);

    // FIFO registers: synchronous reset, registered data/ack/error outputs.
    always @(posedge clk) begin
        if (!rstN) begin
            fW       <= 3'd0;
            fR       <= 3'd0;
            fCount   <= 4'd0;
            fDataOut <= 16'h0000;
            fWrAck   <= 1'b0;
            fOvf     <= 1'b0;
            fUdf     <= 1'b0;
        end else begin
            if (fWok) begin
                fMem[fW] <= bus.data_in;
                fW       <= fW + 3'd1;
            end
            if (fRok) begin
                fDataOut <= fMem[fR];
                fR       <= fR + 3'd1;
            end
            fWrAck <= fWok;
            fOvf   <= bus.wr_en && (fCount == 4'd8);
            fUdf   <= bus.rd_en && (fCount == 4'd0);
            fCount <= fCount + {3'd0, fWok} - {3'd0, fRok};
        end
    end

    assign bus.data_out    = fDataOut;
    assign bus.wr_ack      = fWrAck;
    assign bus.overflow    = fOvf & ~forceOvfZero;
    assign bus.underflow   = fUdf;
    assign bus.full        = (fCount == 4'd8);
    assign bus.empty       = (fCount == 4'd0) ^ flipEmpty;
    assign bus.almostfull  = (fCount == 4'd7) & ~forceAfZero;
    assign bus.almostempty = (fCount == 4'd1);

    typedef struct {
        logic        wr;
        logic        rd;
        logic [15:0] din;
        logic [2:0]  sel;
        int          expOk;
    } vec_t;

    vec_t fillTab [9];

    // Drive one cycle of requests mid-cycle, then wait past the next edge.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [15:0] din);
        @(negedge clk);
        rstN        = 1'b1;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset(input int cycles);
        @(negedge clk);
        rstN      = 1'b0;
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkErr(input logic [2:0] sel, input int expected);
        cntSel = sel;
        #1;
        checkOutput($sformatf("err_cnt[%0d]", sel), {16'h0, errCnt}, expected);
    endtask

    task automatic checkOk(input logic [2:0] sel, input int expected);
        cntSel = sel;
        #1;
        checkOutput($sformatf("ok_cnt[%0d]", sel), {16'h0, okCnt}, expected);
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, " err_vec"}, {24'h0, errVec}, 32'h0);
        checkOutput({tag, " err_sticky"}, {31'h0, errSticky}, 32'h0);
        checkOutput({tag, " first_err_sel"}, {29'h0, firstErrSel}, 32'h0);
        checkOutput({tag, " first_err_cyc"}, firstErrCyc, 32'h0);
        for (int s = 0; s < 8; s++) begin
            checkErr(3'(s), 0);
            checkOk(3'(s), 0);
        end
    endtask

    initial begin
        rstN         = 1'b0;
        checkEn      = 1'b1;
        cntSel       = 3'd0;
        forceOvfZero = 1'b0;
        forceAfZero  = 1'b0;
        flipEmpty    = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_en    = 1'b0;
        bus.data_in  = 16'h0000;

        // Fill with 0x0001..0x0008; the wr_ack correct count tracks the
        // number of compared cycles, the last row checks full with one idle.
        for (int i = 0; i < 8; i++) begin
            fillTab[i] = '{wr: 1'b1, rd: 1'b0, din: 16'(i + 1), sel: 3'd1, expOk: i + 1};
        end
        fillTab[8] = '{wr: 1'b0, rd: 1'b0, din: 16'h0000, sel: 3'd4, expOk: 9};

        doReset(2);
        checkAllClear("reset");

        // Cycles c1..c9
        for (int i = 0; i < 9; i++) begin
            applyStimulus(fillTab[i].wr, fillTab[i].rd, fillTab[i].din);
            checkOk(fillTab[i].sel, fillTab[i].expOk);
            checkErr(fillTab[i].sel, 0);
            checkOutput($sformatf("fill%0d err_vec", i), {24'h0, errVec}, 32'h0);
        end
        checkOutput("fill err_sticky", {31'h0, errSticky}, 32'h0);
        for (int s = 0; s < 8; s++) begin
            checkErr(3'(s), 0);
        end

        // Overflow write at c10; the FIFO's overflow is masked during c11
        applyStimulus(1'b1, 1'b0, 16'h0099);
        checkOutput("ovf pre err_vec", {24'h0, errVec}, 32'h0);
        forceOvfZero = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("ovf err_vec", {24'h0, errVec}, 32'h04);
        checkOutput("ovf err_sticky", {31'h0, errSticky}, 32'h1);
        checkOutput("ovf first_err_sel", {29'h0, firstErrSel}, 32'h2);
        checkOutput("ovf first_err_cyc", firstErrCyc, 32'd10);
        checkOutput("sat first_err_cyc", satFirstCyc, 32'd10);
        forceOvfZero = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("post ovf err_vec", {24'h0, errVec}, 32'h0);
        checkErr(3'd2, 1);
        checkOutput("post ovf sticky", {31'h0, errSticky}, 32'h1);

        // Drain c13..c20, one extra read on empty at c21, idle at c22
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b1, 16'h0000);
            checkOutput($sformatf("drain%0d err_vec", i), {24'h0, errVec}, 32'h0);
        end
        checkOk(3'd0, 8);
        checkErr(3'd0, 0);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("udf err_vec", {24'h0, errVec}, 32'h0);
        checkOk(3'd3, 22);
        checkErr(3'd3, 0);
        checkOk(3'd2, 21);
        checkOk(3'd5, 22);
        checkOk(3'd0, 9);

        // Three entries (c23..c25), then 20 cycles of write+read (c26..c45)
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0010 + 16'(i));
        end
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1, 16'h0020 + 16'(i));
            checkOutput($sformatf("wrrd%0d err_vec", i), {24'h0, errVec}, 32'h0);
        end
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("wrrd idle err_vec", {24'h0, errVec}, 32'h0);
        checkOk(3'd0, 33);
        checkErr(3'd0, 0);

        // almostfull stuck low: fill to 7 (c47..c50), then five idle cycles
        forceAfZero = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0030 + 16'(i));
        end
        checkErr(3'd6, 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(1'b0, 1'b0, 16'h0000);
            checkOutput($sformatf("af%0d err_vec", k), {24'h0, errVec}, 32'h40);
            checkErr(3'd6, k);
            checkOutput($sformatf("af%0d sat err_cnt", k), {30'h0, satErrCnt}, (k > 3) ? 32'd3 : 32'(k));
        end
        applyStimulus(1'b0, 1'b1, 16'h0000);
        checkErr(3'd6, 6);
        forceAfZero = 1'b0;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("af clear err_vec", {24'h0, errVec}, 32'h0);
        checkErr(3'd6, 6);
        checkOutput("af first_err_sel", {29'h0, firstErrSel}, 32'h2);

        // Down to 5 entries, then a one-cycle reset with checking enabled
        applyStimulus(1'b0, 1'b1, 16'h0000);
        doReset(1);
        checkAllClear("midreset");

        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("after reset err_vec", {24'h0, errVec}, 32'h0);
        checkOk(3'd5, 1);
        applyStimulus(1'b1, 1'b0, 16'h00A1);
        applyStimulus(1'b1, 1'b0, 16'h00A2);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("post reset seq err_vec", {24'h0, errVec}, 32'h0);
        checkOk(3'd0, 2);
        checkErr(3'd0, 0);
        checkOutput("post reset seq sticky", {31'h0, errSticky}, 32'h0);

        // A corrupted empty flag is ignored while checking is off
        checkEn   = 1'b0;
        flipEmpty = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("chk off err_vec", {24'h0, errVec}, 32'h0);
        checkOutput("chk off sticky", {31'h0, errSticky}, 32'h0);
        checkOk(3'd5, 6);
        checkErr(3'd5, 0);
        checkEn = 1'b1;
        applyStimulus(1'b0, 1'b0, 16'h0000);
        checkOutput("empty err_vec", {24'h0, errVec}, 32'h20);
        checkOutput("empty sticky", {31'h0, errSticky}, 32'h1);
        checkOutput("empty first_err_sel", {29'h0, firstErrSel}, 32'h5);
        checkOutput("empty first_err_cyc", firstErrCyc, 32'd7);
        checkErr(3'd5, 1);
        checkOk(3'd5, 6);
        flipEmpty = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_scoreboard_checker.md
Name: fifo_scoreboard_checker

Overview:
- Synthesizable, parametrised in-line checker that shadows a synchronous FIFO DUT.
- Keeps a reference model of contents and occupancy, and checks all eight DUT outputs every cycle against model predictions.
- Keeps per-signal saturating error/correct counters and captures the first mismatch.
- Sits beside the FIFO in simulation and emulation builds and replaces end-of-test printouts with readable registers.

Parameters:
DATA_W, 16, FIFO data width
DEPTH, 8, FIFO depth in entries (power of 2, >=4)
AF_TH, DEPTH-1, occupancy at which almostfull is expected
AE_TH, 1, occupancy at which almostempty is expected
CNT_W, 16, width of each error/correct counter (saturating)
CYC_W, 32, width of free-running cycle counter

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
check_en  in  1  1 = compare and count this cycle
wr_en  in  1  DUT write request
rd_en  in  1  DUT read request
data_in  in  DATA_W  DUT write data
data_out  in  DATA_W  DUT read data (registered in DUT)
wr_ack  in  1  DUT write acknowledge (registered)
overflow  in  1  DUT overflow (registered)
underflow  in  1  DUT underflow (registered)
full  in  1  DUT full (combinational from count)
empty  in  1  DUT empty
almostfull  in  1  DUT almostfull
almostempty  in  1  DUT almostempty
cnt_sel  in  3  counter select: 0 data_out, 1 wr_ack, 2 overflow, 3 underflow, 4 full, 5 empty, 6 almostfull, 7 almostempty
err_cnt  out  CNT_W  error count of selected signal, combinational read
ok_cnt  out  CNT_W  correct count of selected signal, combinational read
err_vec  out  8  per-signal mismatch of previous cycle (registered)
err_sticky  out  1  set on first mismatch, held until reset
first_err_sel  out  3  index of lowest mismatching signal on first error
first_err_cyc  out  CYC_W  cycle counter value at first error

Behaviour:
- Reset (rst_n=0 at an edge): model count=0, pointers=0, model memory not cleared. exp_wr_ack/overflow/underflow=0, exp_data_out=0, data_valid=0. All counters, err_vec, err_sticky, first_err_sel and first_err_cyc are 0, and the cycle counter is 0. No compare happens in a reset cycle.
- Model update at each edge with rst_n=1:
  - wr_ok = wr_en & ~mfull. rd_ok = rd_en & ~mempty, where mfull is count==DEPTH and mempty is count==0.
  - exp_wr_ack <= wr_ok; exp_overflow <= wr_en & mfull; exp_underflow <= rd_en & mempty.
  - If rd_ok: exp_data_out <= mem[rptr] and data_valid <= 1; otherwise both hold.
  - count += wr_ok - rd_ok. Pointers wrap modulo DEPTH.
  - Simultaneous wr/rd when full: read only, overflow expected. When empty: write only, underflow expected.
  - The model runs regardless of check_en.
- Expected flags are combinational from model count: full = count==DEPTH; empty = count==0; almostfull = count==AF_TH; almostempty = count==AE_TH.
- Compare: during each cycle with rst_n=1 and check_en=1, each DUT output is compared with its model value.
  - data_out is compared only when data_valid=1; otherwise it counts as neither error nor correct.
  - Results register at the next edge into err_vec, err_cnt[i] (mismatch) and ok_cnt[i] (match). Latency is 1 cycle.
  - Counters saturate at 2^CNT_W-1 and never wrap.
  - When check_en=0, err_vec <= 0 and counters hold.
- First error: on the first edge where any err bit sets and err_sticky=0, latch first_err_sel (lowest set index) and first_err_cyc (cycle counter value of the compared cycle), then set err_sticky. Later errors do not change these registers.
- Cycle counter increments every edge with rst_n=1 and wraps at 2^CYC_W.
- Reset mid-operation: clears model and statistics in the same edge. The next cycle compares against reset expectations (empty=1, almostempty only if AE_TH==0).

Test Plan:
- Reset, then 8 writes of 0x0001..0x0008 with DEPTH=8 against a correct FIFO -> wr_ack ok_cnt=8, full ok in last cycle, err_sticky=0, all err_cnt=0.
- From full, one more write -> exp_overflow=1 next cycle. A DUT that drives overflow=0 gives err_vec[2]=1, first_err_sel=2, first_err_cyc equal to that cycle.
- 8 reads after the fill -> data_out matches 0x0001..0x0008 in order (ok_cnt[0]=8). A 9th read expects underflow=1 and empty=1.
- Simultaneous wr/rd at count=3 for 20 cycles with wrapping pointers -> count stays 3, data order preserved, zero errors.
- DUT almostfull stuck at 0 while filling to 7 -> err_cnt[6] increments only in cycles with count==7. With CNT_W=2, forced mismatches hold err_cnt at 3 (saturation).
- rst_n=0 for 1 cycle at count=5 with check_en=1 -> all counters 0. The next cycle expects empty=1, and the following write/read sequence checks clean.
